// File: rtl/seat_pkg.sv
// ---------------------------------------------------------------------------
// seat_pkg
// Shared types and widths for the seat access scheduler and its arbiter.
//   seat_state_t  : state of one seat in the seating memories
//   op_t          : kiosk operation code
//   resp_t        : response code returned to the kiosk with its ack
//   sched_state_t : scheduler FSM states
//   count_step()  : saturating up/down step for the occupied-seat counter
// ---------------------------------------------------------------------------
package seat_pkg;

    localparam int STUDENT_W = 25;
    localparam int SEAT_W    = 5;
    localparam int TIME_W    = 11;
    localparam int COUNT_W   = 6;

    typedef enum logic [1:0] {
        SEAT_EMPTY    = 2'b00,
        SEAT_OCCUPIED = 2'b01,
        SEAT_AWAY     = 2'b10,
        SEAT_RESERVED = 2'b11
    } seat_state_t;

    typedef enum logic [1:0] {
        OP_CHECKIN  = 2'b00,
        OP_AWAY     = 2'b01,
        OP_RETURN   = 2'b10,
        OP_CHECKOUT = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        RESP_OK        = 2'b00,
        RESP_BAD_STATE = 2'b01,
        RESP_NOT_OWNER = 2'b10,
        RESP_RANGE     = 2'b11
    } resp_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_GRANT_CHK = 2'b01,
        ST_COMMIT    = 2'b10,
        ST_RESP      = 2'b11
    } sched_state_t;

    // Counter never exceeds limit and never wraps below zero.
    function automatic logic [COUNT_W-1:0] count_step(
        input logic [COUNT_W-1:0] count,
        input logic               inc,
        input logic               dec,
        input logic [COUNT_W-1:0] limit
    );
        logic [COUNT_W-1:0] result;
        result = count;
        if (inc && !dec && (count < limit)) begin
            result = count + COUNT_W'(1);
        end else if (dec && !inc && (count != '0)) begin
            result = count - COUNT_W'(1);
        end
        return result;
    endfunction

endpackage

// File: rtl/seat_rr_arbiter.sv
// ---------------------------------------------------------------------------
// seat_rr_arbiter
// Round-robin arbiter over N_REQ requesters. The search starts at the
// internal pointer; on an advance strobe with a valid grant the pointer
// moves to the winner + 1 (mod N_REQ).
// Ports:
//   clk, rst     : clock, synchronous active-high reset (pointer -> 0)
//   req          : request vector
//   advance      : accept the current grant and move the pointer
//   grant        : one-hot grant
//   grant_idx    : index of the granted requester
//   grant_valid  : at least one request present
// ---------------------------------------------------------------------------
module seat_rr_arbiter #(
    parameter  int N_REQ = 4,
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             advance,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] cand;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        grant       = '0;
        cand        = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = IDX_W'((int'(ptr_q) + i) % N_REQ);
            if (!grant_valid && req[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
        if (grant_valid) begin
            grant[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance && grant_valid) begin
            ptr_d = (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/seat_access_scheduler.sv
// ---------------------------------------------------------------------------
// seat_access_scheduler
// Arbitrates kiosk seat transactions onto the single write port of the
// seating memories. Keeps a shadow seat-state/owner table, checks legality,
// issues at most one mem_write per transaction and acks the winning kiosk.
// Transaction timing: grant in IDLE at t, mem_write at t+2, ack at t+3.
// Optional feature macro: SEAT_AWAY_TIMEOUT_EN -- releases seats that have
// been AWAY for at least LIMIT_TIME timer units via an idle-time sweep.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   kiosk_req/op/student/seat: per-kiosk request and its payload (packed)
//   kiosk_ack, resp_code     : one-cycle ack to the winner and its response
//   mem_write, mem_student_no, mem_seat_no, mem_seat_state : memory write
//   time_in                  : free-running timer (timeout build only)
//   busy                     : FSM not in IDLE
//   occupied_count           : seats currently OCCUPIED or AWAY
// ---------------------------------------------------------------------------
module seat_access_scheduler
    import seat_pkg::*;
#(
    parameter int                N_KIOSK    = 4,
    parameter int                N_SEATS    = 32,
    parameter logic [TIME_W-1:0] LIMIT_TIME = 11'd60
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_KIOSK-1:0]             kiosk_req,
    input  logic [N_KIOSK*2-1:0]           kiosk_op,
    input  logic [N_KIOSK*STUDENT_W-1:0]   kiosk_student,
    input  logic [N_KIOSK*SEAT_W-1:0]      kiosk_seat,
    output logic [N_KIOSK-1:0]             kiosk_ack,
    output logic [1:0]                     resp_code,
    output logic                           mem_write,
    output logic [STUDENT_W-1:0]           mem_student_no,
    output logic [SEAT_W-1:0]              mem_seat_no,
    output logic [1:0]                     mem_seat_state,
    input  logic [TIME_W-1:0]              time_in,
    output logic                           busy,
    output logic [COUNT_W-1:0]             occupied_count
);

    localparam int KIDX_W = $clog2(N_KIOSK);

    sched_state_t state_q, state_d;

    logic [KIDX_W-1:0]    kidx_q, kidx_d;
    op_t                  op_q, op_d;
    logic [STUDENT_W-1:0] student_q, student_d;
    logic [SEAT_W-1:0]    seat_q, seat_d;
    resp_t                resp_q, resp_d;
    logic                 legal_q, legal_d;
    seat_state_t          new_state_q, new_state_d;
    logic [STUDENT_W-1:0] new_owner_q, new_owner_d;
    logic                 sweep_txn_q, sweep_txn_d;
    logic [COUNT_W-1:0]   count_q, count_d;

    seat_state_t          seat_state_q [N_SEATS];
    seat_state_t          seat_state_d [N_SEATS];
    logic [STUDENT_W-1:0] owner_q      [N_SEATS];
    logic [STUDENT_W-1:0] owner_d      [N_SEATS];

    logic [N_KIOSK-1:0]   arb_grant;
    logic [KIDX_W-1:0]    arb_idx;
    logic                 arb_valid;

    logic [1:0]           grant_op;
    logic [STUDENT_W-1:0] grant_student;
    logic [SEAT_W-1:0]    grant_seat;

    logic                 in_range;
    logic                 owner_match;
    seat_state_t          cur_state;
    logic [STUDENT_W-1:0] cur_owner;
    resp_t                chk_resp;
    seat_state_t          chk_state;
    logic [STUDENT_W-1:0] chk_owner;

    logic                 sweep_fire;
    logic [SEAT_W-1:0]    sweep_seat;

    seat_rr_arbiter #(.N_REQ(N_KIOSK)) u_arb (
        .clk         (clk),
        .rst         (rst),
        .req         (kiosk_req),
        .advance     (state_q == ST_IDLE),
        .grant       (arb_grant),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    // One-hot mux of the winning kiosk's payload.
    always_comb begin
        grant_op      = '0;
        grant_student = '0;
        grant_seat    = '0;
        for (int k = 0; k < N_KIOSK; k++) begin
            if (arb_grant[k]) begin
                grant_op      = kiosk_op[k*2 +: 2];
                grant_student = kiosk_student[k*STUDENT_W +: STUDENT_W];
                grant_seat    = kiosk_seat[k*SEAT_W +: SEAT_W];
            end
        end
    end

    // Legality of the latched op against the shadow table.
    // Priority: RANGE, then BAD_STATE, then NOT_OWNER.
    always_comb begin
        cur_state   = SEAT_EMPTY;
        cur_owner   = '0;
        chk_resp    = RESP_OK;
        chk_state   = SEAT_EMPTY;
        chk_owner   = '0;
        in_range    = ({27'd0, seat_q} < 32'(N_SEATS));
        if (in_range) begin
            cur_state = seat_state_q[seat_q];
            cur_owner = owner_q[seat_q];
        end
        owner_match = (cur_owner == student_q);
        if (!in_range) begin
            chk_resp = RESP_RANGE;
        end else begin
            case (op_q)
                OP_CHECKIN: begin
                    if (cur_state != SEAT_EMPTY) chk_resp = RESP_BAD_STATE;
                    else begin
                        chk_state = SEAT_OCCUPIED;
                        chk_owner = student_q;
                    end
                end
                OP_AWAY: begin
                    if (cur_state != SEAT_OCCUPIED) chk_resp = RESP_BAD_STATE;
                    else if (!owner_match)          chk_resp = RESP_NOT_OWNER;
                    else begin
                        chk_state = SEAT_AWAY;
                        chk_owner = cur_owner;
                    end
                end
                OP_RETURN: begin
                    if (cur_state != SEAT_AWAY) chk_resp = RESP_BAD_STATE;
                    else if (!owner_match)      chk_resp = RESP_NOT_OWNER;
                    else begin
                        chk_state = SEAT_OCCUPIED;
                        chk_owner = cur_owner;
                    end
                end
                OP_CHECKOUT: begin
                    if ((cur_state != SEAT_OCCUPIED) && (cur_state != SEAT_AWAY)) chk_resp = RESP_BAD_STATE;
                    else if (!owner_match) chk_resp = RESP_NOT_OWNER;
                    else begin
                        chk_state = SEAT_EMPTY;
                        chk_owner = '0;
                    end
                end
                default: chk_resp = RESP_BAD_STATE;
            endcase
        end
    end

`ifdef SEAT_AWAY_TIMEOUT_EN
    logic [TIME_W-1:0] stamp_q [N_SEATS];
    logic [TIME_W-1:0] stamp_d [N_SEATS];
    logic [SEAT_W-1:0] sweep_ptr_q, sweep_ptr_d;
    logic [TIME_W-1:0] away_elapsed;
    logic              sweep_slot;

    // Elapsed time is taken mod 2^TIME_W so the free-running timer may wrap.
    always_comb begin
        sweep_slot   = (state_q == ST_IDLE) && !(|kiosk_req);
        away_elapsed = time_in - stamp_q[sweep_ptr_q];
        sweep_fire   = sweep_slot && (seat_state_q[sweep_ptr_q] == SEAT_AWAY) &&
                       (away_elapsed >= LIMIT_TIME);
        sweep_seat   = sweep_ptr_q;
    end

    // Pointer visits one seat per idle cycle; stamp captured on AWAY commit.
    always_comb begin
        sweep_ptr_d = sweep_ptr_q;
        stamp_d     = stamp_q;
        if (sweep_slot) begin
            sweep_ptr_d = (sweep_ptr_q == SEAT_W'(N_SEATS - 1)) ? '0 : sweep_ptr_q + SEAT_W'(1);
        end
        if ((state_q == ST_COMMIT) && legal_q && !sweep_txn_q && (op_q == OP_AWAY)) begin
            stamp_d[seat_q] = time_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sweep_ptr_q <= '0;
            for (int i = 0; i < N_SEATS; i++) begin
                stamp_q[i] <= '0;
            end
        end else begin
            sweep_ptr_q <= sweep_ptr_d;
            stamp_q     <= stamp_d;
        end
    end
`else
    logic unused_time;
    assign unused_time = ^{time_in, LIMIT_TIME};
    assign sweep_fire  = 1'b0;
    assign sweep_seat  = '0;
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; sweep releases skip the ack phase.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_valid)       state_d = ST_GRANT_CHK;
                else if (sweep_fire) state_d = ST_COMMIT;
            end
            ST_GRANT_CHK: state_d = ST_COMMIT;
            ST_COMMIT:    state_d = sweep_txn_q ? ST_IDLE : ST_RESP;
            ST_RESP:      state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // FSM outputs; rst forces them low so an aborted transaction never writes or acks.
    always_comb begin
        kiosk_ack      = '0;
        resp_code      = '0;
        mem_write      = 1'b0;
        mem_student_no = '0;
        mem_seat_no    = '0;
        mem_seat_state = '0;
        busy           = (state_q != ST_IDLE);
        occupied_count = count_q;
        if (!rst) begin
            case (state_q)
                ST_COMMIT: begin
                    if (legal_q) begin
                        mem_write      = 1'b1;
                        mem_student_no = new_owner_q;
                        mem_seat_no    = seat_q;
                        mem_seat_state = new_state_q;
                    end
                end
                ST_RESP: begin
                    if (!sweep_txn_q) begin
                        kiosk_ack[kidx_q] = 1'b1;
                        resp_code         = resp_q;
                    end
                end
                default: ;
            endcase
        end
    end

    // Transaction latch, legality result and shadow table update.
    always_comb begin
        kidx_d       = kidx_q;
        op_d         = op_q;
        student_d    = student_q;
        seat_d       = seat_q;
        resp_d       = resp_q;
        legal_d      = legal_q;
        new_state_d  = new_state_q;
        new_owner_d  = new_owner_q;
        sweep_txn_d  = sweep_txn_q;
        count_d      = count_q;
        seat_state_d = seat_state_q;
        owner_d      = owner_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    kidx_d      = arb_idx;
                    op_d        = op_t'(grant_op);
                    student_d   = grant_student;
                    seat_d      = grant_seat;
                    sweep_txn_d = 1'b0;
                end else if (sweep_fire) begin
                    seat_d      = sweep_seat;
                    new_state_d = SEAT_EMPTY;
                    new_owner_d = '0;
                    legal_d     = 1'b1;
                    resp_d      = RESP_OK;
                    sweep_txn_d = 1'b1;
                end
            end
            ST_GRANT_CHK: begin
                resp_d      = chk_resp;
                legal_d     = (chk_resp == RESP_OK);
                new_state_d = chk_state;
                new_owner_d = chk_owner;
            end
            ST_COMMIT: begin
                if (legal_q) begin
                    seat_state_d[seat_q] = new_state_q;
                    owner_d[seat_q]      = new_owner_q;
                    count_d = count_step(count_q,
                                         !sweep_txn_q && (op_q == OP_CHECKIN),
                                         sweep_txn_q || (op_q == OP_CHECKOUT),
                                         COUNT_W'(N_SEATS));
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            kidx_q      <= '0;
            op_q        <= OP_CHECKIN;
            student_q   <= '0;
            seat_q      <= '0;
            resp_q      <= RESP_OK;
            legal_q     <= 1'b0;
            new_state_q <= SEAT_EMPTY;
            new_owner_q <= '0;
            sweep_txn_q <= 1'b0;
            count_q     <= '0;
            for (int i = 0; i < N_SEATS; i++) begin
                seat_state_q[i] <= SEAT_EMPTY;
                owner_q[i]      <= '0;
            end
        end else begin
            kidx_q       <= kidx_d;
            op_q         <= op_d;
            student_q    <= student_d;
            seat_q       <= seat_d;
            resp_q       <= resp_d;
            legal_q      <= legal_d;
            new_state_q  <= new_state_d;
            new_owner_q  <= new_owner_d;
            sweep_txn_q  <= sweep_txn_d;
            count_q      <= count_d;
            seat_state_q <= seat_state_d;
            owner_q      <= owner_d;
        end
    end

endmodule

// File: tb/tb_seat_access_scheduler.sv
// ---------------------------------------------------------------------------
// tb_seat_access_scheduler
// Scoreboard bench: each kiosk transaction is run through a reference seat
// model when driven; expected writes and acks are queued and compared when
// the scheduler produces them. Instantiated with N_SEATS=20 so the range
// check can be exercised with in-field seat numbers.
// ---------------------------------------------------------------------------
module tb_seat_access_scheduler;
    import seat_pkg::*;

    localparam int NK = 4;
    localparam int NS = 20;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [NK-1:0]           kiosk_req = '0;
    logic [NK*2-1:0]         kiosk_op = '0;
    logic [NK*STUDENT_W-1:0] kiosk_student = '0;
    logic [NK*SEAT_W-1:0]    kiosk_seat = '0;
    logic [NK-1:0]           kiosk_ack;
    logic [1:0]              resp_code;
    logic                    mem_write;
    logic [STUDENT_W-1:0]    mem_student_no;
    logic [SEAT_W-1:0]       mem_seat_no;
    logic [1:0]              mem_seat_state;
    logic [TIME_W-1:0]       time_in = '0;
    logic                    busy;
    logic [COUNT_W-1:0]      occupied_count;

    seat_access_scheduler #(.N_KIOSK(NK), .N_SEATS(NS), .LIMIT_TIME(11'd60)) dut (
        .clk            (clk),
        .rst            (rst),
        .kiosk_req      (kiosk_req),
        .kiosk_op       (kiosk_op),
        .kiosk_student  (kiosk_student),
        .kiosk_seat     (kiosk_seat),
        .kiosk_ack      (kiosk_ack),
        .resp_code      (resp_code),
        .mem_write      (mem_write),
        .mem_student_no (mem_student_no),
        .mem_seat_no    (mem_seat_no),
        .mem_seat_state (mem_seat_state),
        .time_in        (time_in),
        .busy           (busy),
        .occupied_count (occupied_count)
    );

    always #5 clk = ~clk;

    int cycleCnt = 0;
    int lastWriteCycle = -1;
    int checks = 0;
    int errors = 0;

    always @(posedge clk) begin
        cycleCnt <= cycleCnt + 1;
        time_in  <= time_in + 11'd1;
    end

    logic [31:0] writeQ[$];
    logic [5:0]  ackQ[$];

    logic [1:0]  mState [32];
    logic [24:0] mOwner [32];
    int          mCount;
    int          rrPtr;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at cycle %0d", tag, obs, exp, cycleCnt);
        end
    endtask

    task automatic modelClear();
        for (int i = 0; i < 32; i++) begin
            mState[i] = 2'b00;
            mOwner[i] = '0;
        end
        mCount = 0;
        rrPtr  = 0;
    endtask

    // Reference behaviour of one granted transaction, queued in grant order.
    task automatic modelOp(input int k, input logic [1:0] op, input logic [24:0] stu,
                           input logic [4:0] seat, output bit legal);
        logic [1:0]  resp;
        logic [1:0]  ns;
        logic [24:0] no;
        legal = 1'b0;
        resp  = 2'b00;
        ns    = 2'b00;
        no    = '0;
        if (int'(seat) >= NS) begin
            resp = 2'b11;
        end else begin
            case (op)
                2'b00: if (mState[seat] == 2'b00) begin legal = 1'b1; ns = 2'b01; no = stu; end
                       else resp = 2'b01;
                2'b01: if (mState[seat] != 2'b01) resp = 2'b01;
                       else if (mOwner[seat] != stu) resp = 2'b10;
                       else begin legal = 1'b1; ns = 2'b10; no = stu; end
                2'b10: if (mState[seat] != 2'b10) resp = 2'b01;
                       else if (mOwner[seat] != stu) resp = 2'b10;
                       else begin legal = 1'b1; ns = 2'b01; no = stu; end
                default: if (mState[seat] != 2'b01 && mState[seat] != 2'b10) resp = 2'b01;
                         else if (mOwner[seat] != stu) resp = 2'b10;
                         else begin legal = 1'b1; ns = 2'b00; no = '0; end
            endcase
        end
        ackQ.push_back({4'(1 << k), resp});
        if (legal) begin
            writeQ.push_back({no, seat, ns});
            if (op == 2'b00) mCount++;
            if (op == 2'b11) mCount--;
            mState[seat] = ns;
            mOwner[seat] = no;
        end
        rrPtr = (k + 1) % NK;
    endtask

    task automatic setKiosk(input int k, input logic [1:0] op, input logic [24:0] stu, input logic [4:0] seat);
        kiosk_op[k*2 +: 2]                    = op;
        kiosk_student[k*STUDENT_W +: STUDENT_W] = stu;
        kiosk_seat[k*SEAT_W +: SEAT_W]        = seat;
    endtask

    task automatic applyStimulus(input int k, input logic [1:0] op, input logic [24:0] stu, input logic [4:0] seat);
        bit legal;
        bit got;
        int start;
        @(negedge clk);
        setKiosk(k, op, stu, seat);
        kiosk_req[k] = 1'b1;
        start = cycleCnt;
        modelOp(k, op, stu, seat, legal);
        got = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            @(negedge clk);
            if (kiosk_ack != '0) got = 1'b1;
        end
        kiosk_req[k] = 1'b0;
        checkOutput("ack_seen", 32'(got), 32'd1);
        if (got) begin
            checkOutput("ack_latency", 32'(cycleCnt - start), 32'd3);
            if (legal) checkOutput("write_latency", 32'(lastWriteCycle - start), 32'd2);
        end
        checkOutput("occupied_count", 32'(occupied_count), 32'(mCount));
    endtask

    task automatic doReset();
        rst       = 1'b1;
        kiosk_req = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        modelClear();
    endtask

    // Scoreboard monitor: every write and ack must match the next expectation.
    always @(negedge clk) begin
        if (mem_write === 1'b1) begin
            lastWriteCycle <= cycleCnt;
            if (writeQ.size() == 0) checkOutput("unexpected_write", 32'd1, 32'd0);
            else checkOutput("mem_write_data", {mem_student_no, mem_seat_no, mem_seat_state}, writeQ.pop_front());
        end
        if (kiosk_ack !== '0) begin
            if (ackQ.size() == 0) checkOutput("unexpected_ack", 32'(kiosk_ack), 32'd0);
            else checkOutput("ack_resp", 32'({kiosk_ack, resp_code}), 32'(ackQ.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit legal;
        int nAck;
        int ackCycles [5];

        modelClear();
        doReset();
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_mem_write", 32'(mem_write), 32'd0);
        checkOutput("reset_ack", 32'(kiosk_ack), 32'd0);
        checkOutput("reset_count", 32'(occupied_count), 32'd0);
        checkOutput("reset_mem_bus", {mem_student_no, mem_seat_no, mem_seat_state}, 32'd0);

        // Basic check-in, then conflicting check-in on an occupied seat.
        applyStimulus(0, OP_CHECKIN, 25'd1234, 5'd3);
        applyStimulus(1, OP_CHECKIN, 25'd99,   5'd3);

        // Ownership and state transitions.
        applyStimulus(2, OP_AWAY,     25'd99,   5'd3);
        applyStimulus(3, OP_AWAY,     25'd1234, 5'd3);
        applyStimulus(0, OP_RETURN,   25'd1234, 5'd3);
        applyStimulus(1, OP_CHECKOUT, 25'd99,   5'd3);
        applyStimulus(2, OP_RETURN,   25'd1234, 5'd3);

        // Range boundaries and checkout/double-checkout.
        applyStimulus(3, OP_CHECKIN,  25'd7,  5'd31);
        applyStimulus(0, OP_CHECKIN,  25'd7,  5'd20);
        applyStimulus(1, OP_CHECKIN,  25'd42, 5'd19);
        applyStimulus(2, OP_CHECKOUT, 25'd42, 5'd19);
        applyStimulus(3, OP_CHECKOUT, 25'd42, 5'd19);

        // All kiosks request at once and keep requesting: round-robin order.
        @(negedge clk);
        for (int k = 0; k < NK; k++) setKiosk(k, OP_CHECKIN, 25'(500 + k), 5'(10 + k));
        for (int g = 0; g < 5; g++) begin
            int w;
            w = rrPtr;
            modelOp(w, OP_CHECKIN, 25'(500 + w), 5'(10 + w), legal);
        end
        kiosk_req = '1;
        nAck = 0;
        for (int i = 0; i < 40 && nAck < 5; i++) begin
            @(negedge clk);
            if (kiosk_ack != '0) begin
                ackCycles[nAck] = cycleCnt;
                nAck++;
                if (nAck == 5) kiosk_req = '0;
            end
        end
        kiosk_req = '0;
        checkOutput("rr_ack_count", 32'(nAck), 32'd5);
        for (int i = 1; i < 5; i++) begin
            if (i < nAck) checkOutput("rr_gap", 32'(ackCycles[i] - ackCycles[i-1]), 32'd4);
        end
        checkOutput("rr_count", 32'(occupied_count), 32'(mCount));

        // Reset during COMMIT aborts the transaction and clears the table.
        @(negedge clk);
        setKiosk(1, OP_CHECKIN, 25'd77, 5'd7);
        kiosk_req[1] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst       = 1'b1;
        kiosk_req = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        modelClear();
        checkOutput("abort_count", 32'(occupied_count), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        applyStimulus(0, OP_CHECKIN, 25'd5, 5'd7);
        applyStimulus(1, OP_CHECKIN, 25'd6, 5'd3);

        repeat (4) @(negedge clk);
        checkOutput("pending_writes", 32'(writeQ.size()), 32'd0);
        checkOutput("pending_acks", 32'(ackQ.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
